// File: rtl/mux_pkg.sv
// Shared types and constants for the bit-steering demux: FSM state
// encoding, default geometry and the word-complete test.
package mux_pkg;

    localparam int DEMUX_WIDTH = 16;
    localparam int DEMUX_SEL_W = 4;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } demux_state_e;

    // True once every bit position of the word has been written.
    function automatic logic all_ones(input logic [DEMUX_WIDTH-1:0] mask);
        return &mask;
    endfunction

endpackage

// File: rtl/demux_out_reg.sv
// One-entry valid/ready output register carrying an assembled word and its
// write mask; contents stay frozen until the next load.
module demux_out_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [WIDTH-1:0] load_mask,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_mask
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] mask_r;

    // Load wins over a handshake drain so back-to-back words keep valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
            mask_r  <= {WIDTH{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            mask_r  <= load_mask;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_mask  = mask_r;

endmodule

// File: rtl/bit_demux16.sv
// Steers one data bit per beat into an addressed position of a staging word
// and hands the word off when all positions are written or on flush.
module bit_demux16
    import mux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int SEL_W = DEMUX_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_mask,
    output logic             dup_err
);

    logic [WIDTH-1:0] stage_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] next_stage_s;
    logic [WIDTH-1:0] next_mask_s;
    logic [WIDTH-1:0] load_data_s;
    logic [WIDTH-1:0] load_mask_s;
    demux_state_e     state_r;
    demux_state_e     state_next_s;
    logic             accept_s;
    logic             dup_s;
    logic             close_s;
    logic             slot_free_s;
    logic             load_s;
    logic             clear_s;
    logic             dup_err_r;

    assign in_ready    = (state_r == COLLECT);
    assign accept_s    = in_valid & in_ready;
    assign slot_free_s = ~out_valid | out_ready;

    // Post-write view of the staging word; close decisions use these values.
    always_comb begin
        next_stage_s = stage_r;
        next_mask_s  = mask_r;
        dup_s        = 1'b0;
        if (accept_s) begin
            next_stage_s[in_sel] = in_bit;
            next_mask_s[in_sel]  = 1'b1;
            dup_s                = mask_r[in_sel];
        end else begin
            dup_s = 1'b0;
        end
    end

    assign close_s = (state_r == COLLECT) &&
                     (all_ones(next_mask_s) || (flush && (|next_mask_s)));

    // Next-state and output-register load control.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        clear_s      = 1'b0;
        load_data_s  = next_stage_s;
        load_mask_s  = next_mask_s;
        case (state_r)
            COLLECT: begin
                if (close_s && slot_free_s) begin
                    load_s  = 1'b1;
                    clear_s = 1'b1;
                end else if (close_s) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            HOLD: begin
                // The retained word waits here until the consumer drains the slot.
                load_data_s = stage_r;
                load_mask_s = mask_r;
                if (out_valid && out_ready) begin
                    load_s       = 1'b1;
                    clear_s      = 1'b1;
                    state_next_s = COLLECT;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = COLLECT;
                clear_s      = 1'b1;
            end
        endcase
    end

    // Staging word, mask, FSM state and duplicate-write flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= COLLECT;
            stage_r   <= {WIDTH{1'b0}};
            mask_r    <= {WIDTH{1'b0}};
            dup_err_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            dup_err_r <= dup_s;
            if (clear_s) begin
                stage_r <= {WIDTH{1'b0}};
                mask_r  <= {WIDTH{1'b0}};
            end else begin
                stage_r <= next_stage_s;
                mask_r  <= next_mask_s;
            end
        end
    end

    assign dup_err = dup_err_r;

    demux_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .load_data(load_data_s),
        .load_mask(load_mask_s),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_mask (out_mask)
    );

endmodule

// File: tb/tb_bit_demux16.sv
// Directed-vector bench for bit_demux16 with hand-computed expected words.
module tb_bit_demux16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic [3:0]  in_sel;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] out_mask;
    logic        dup_err;

    int checks_r   = 0;
    int failures_r = 0;
    logic dup_seen_r;
    logic [15:0] word_r;

    bit_demux16 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bit   (in_bit),
        .in_sel   (in_sel),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_mask (out_mask),
        .dup_err  (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_r++;
        if (act !== exp) begin
            failures_r++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] s, input logic b);
        in_valid = 1'b1;
        in_sel   = s;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
        dup_seen_r = dup_seen_r | dup_err;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_sel = 4'd0;
        flush = 1'b0; out_ready = 1'b0; dup_seen_r = 1'b0;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        check("rst_mask", {16'd0, out_mask}, 32'd0);
        check("rst_dup", {31'd0, dup_err}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Sequential fill with consumer always ready
        out_ready = 1'b1;
        word_r = 16'hA5C3;
        dup_seen_r = 1'b0;
        for (int i = 0; i < 16; i++) begin
            beat(i[3:0], word_r[i]);
            if (i == 14) check("seq_not_early", {31'd0, out_valid}, 32'd0);
        end
        check("seq_valid", {31'd0, out_valid}, 32'd1);
        check("seq_data", {16'd0, out_data}, 32'h0000A5C3);
        check("seq_mask", {16'd0, out_mask}, 32'h0000FFFF);
        check("seq_no_dup", {31'd0, dup_seen_r}, 32'd0);
        tick();
        check("seq_drained", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Out-of-order fill, then a single handshake
        word_r = 16'h1234;
        for (int i = 15; i >= 0; i--) beat(i[3:0], word_r[i]);
        check("ooo_valid", {31'd0, out_valid}, 32'd1);
        check("ooo_data", {16'd0, out_data}, 32'h00001234);
        check("ooo_mask", {16'd0, out_mask}, 32'h0000FFFF);
        tick();
        check("ooo_stable", {16'd0, out_data}, 32'h00001234);
        drain();
        check("ooo_after_hs", {31'd0, out_valid}, 32'd0);
        check("ooo_data_held", {16'd0, out_data}, 32'h00001234);

        // Partial flush, then a flush on an empty word
        beat(4'd3, 1'b1);
        beat(4'd7, 1'b1);
        check("pf_not_yet", {31'd0, out_valid}, 32'd0);
        do_flush();
        check("pf_valid", {31'd0, out_valid}, 32'd1);
        check("pf_data", {16'd0, out_data}, 32'h00000088);
        check("pf_mask", {16'd0, out_mask}, 32'h00000088);
        drain();
        check("pf_drained", {31'd0, out_valid}, 32'd0);
        do_flush();
        check("empty_flush", {31'd0, out_valid}, 32'd0);
        tick();
        check("empty_flush2", {31'd0, out_valid}, 32'd0);

        // Duplicate write to position 2
        beat(4'd2, 1'b1);
        check("dup_first", {31'd0, dup_err}, 32'd0);
        beat(4'd2, 1'b0);
        check("dup_pulse", {31'd0, dup_err}, 32'd1);
        do_flush();
        check("dup_one_cycle", {31'd0, dup_err}, 32'd0);
        check("dup_valid", {31'd0, out_valid}, 32'd1);
        check("dup_data", {16'd0, out_data}, 32'h00000000);
        check("dup_mask", {16'd0, out_mask}, 32'h00000004);
        drain();

        // Backpressure: second word parks in HOLD
        for (int i = 0; i < 16; i++) beat(i[3:0], 1'b1);
        check("bp_a_data", {16'd0, out_data}, 32'h0000FFFF);
        check("bp_a_ready", {31'd0, in_ready}, 32'd1);
        word_r = 16'h00FF;
        for (int i = 0; i < 16; i++) beat(i[3:0], word_r[i]);
        check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_data", {16'd0, out_data}, 32'h0000FFFF);
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        do_flush();
        check("bp_hold_stays", {31'd0, in_ready}, 32'd0);
        drain();
        check("bp_b_data", {16'd0, out_data}, 32'h000000FF);
        check("bp_b_mask", {16'd0, out_mask}, 32'h0000FFFF);
        check("bp_b_valid", {31'd0, out_valid}, 32'd1);
        check("bp_b_ready", {31'd0, in_ready}, 32'd1);
        drain();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Async reset mid-word with a word waiting at the output
        beat(4'd0, 1'b1);
        do_flush();
        for (int i = 4; i < 8; i++) beat(i[3:0], 1'b1);
        check("ar1_pre_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #2;
        check("ar1_valid", {31'd0, out_valid}, 32'd0);
        check("ar1_data", {16'd0, out_data}, 32'd0);
        check("ar1_mask", {16'd0, out_mask}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Async reset while in HOLD
        for (int i = 0; i < 16; i++) beat(i[3:0], 1'b1);
        for (int i = 0; i < 16; i++) beat(i[3:0], 1'b0);
        check("ar2_in_hold", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #2;
        check("ar2_valid", {31'd0, out_valid}, 32'd0);
        check("ar2_data", {16'd0, out_data}, 32'd0);
        check("ar2_mask", {16'd0, out_mask}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar2_ready", {31'd0, in_ready}, 32'd1);

        // Fresh fill after reset yields only the new word
        out_ready = 1'b1;
        word_r = 16'h5A3C;
        dup_seen_r = 1'b0;
        for (int i = 0; i < 16; i++) beat(i[3:0], word_r[i]);
        check("post_data", {16'd0, out_data}, 32'h00005A3C);
        check("post_mask", {16'd0, out_mask}, 32'h0000FFFF);
        check("post_no_dup", {31'd0, dup_seen_r}, 32'd0);
        tick();
        check("post_no_stale", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule

// File: doc/bit_demux16.md
Name: bit_demux16

Overview:
- Inverse of the 16:1 bit-select mux: takes one data bit plus a 4-bit select per beat and steers it into position `sel` of a 16-bit staging word.
- Staging word is handed off via a valid/ready output register when all 16 positions are written, or early on `flush`.
- Sits downstream of any bit-serial source that addresses bits explicitly, e.g. a scan or readback path reassembling a 16-bit word.

Parameters:
- WIDTH, 16, output word width; must equal 2**SEL_W.
- SEL_W, 4, select width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat or flush this cycle.
- in_bit  input  1  data bit to deposit.
- in_sel  input  SEL_W  destination bit index, 0..15.
- flush  input  1  close the current partial word; sampled only when in_ready=1.
- out_valid  output  1  out_data/out_mask hold a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  assembled word; unwritten bits are 0.
- out_mask  output  WIDTH  1 = bit written in this word.
- dup_err  output  1  one-cycle pulse when a beat overwrites an already-written position.

Behaviour:
- Reset (async, rst_n=0):
  - stage=0, mask=0, state=COLLECT.
  - out_valid=0, out_data=0, out_mask=0, dup_err=0.
  - in_ready=1 once reset deasserts.
- Accept: a beat is taken when in_valid & in_ready.
  - stage[in_sel] <= in_bit; mask[in_sel] <= 1.
  - If mask[in_sel] was already 1: the bit is overwritten (last write wins) and dup_err=1 the next cycle.
- Close condition, evaluated on the post-write values in the same cycle:
  - next_mask == all-ones, or
  - flush & in_ready & next_mask != 0.
  - flush with next_mask == 0 is ignored; no empty words are emitted.
- Output slot free = !out_valid | out_ready.
- On close with slot free:
  - out_data <= next_stage, out_mask <= next_mask, out_valid <= 1.
  - stage and mask cleared.
  - State stays COLLECT; latency is 1 cycle from the closing beat to out_valid.
- On close with slot busy:
  - next_stage/next_mask are retained and state goes to HOLD.
  - In HOLD: in_ready=0 and flush is ignored.
  - On the cycle out_valid & out_ready: held word moves to the output register, stage/mask clear, state goes to COLLECT.
  - out_valid therefore stays 1 continuously (back-to-back words).
- In COLLECT, in_ready=1, including while out_valid=1. The output register plus staging register form a 2-deep buffer.
- Output handshake: out_valid & out_ready with no new word → out_valid <= 0. out_data/out_mask hold their last values.
- out_data/out_mask must stay stable while out_valid & !out_ready.
- Simultaneous events:
  - Accept + flush in the same cycle: the beat is included in the flushed word.
  - Close + output handshake in the same cycle: treated as slot free; no HOLD entry.
- Reset mid-word or in HOLD: everything is discarded and reset values apply immediately.
- dup_err is registered and never blocks acceptance.

Decomposition:
- Shared package mux_pkg:
  - state typedef {COLLECT, HOLD}.
  - Constants DEMUX_WIDTH=16, DEMUX_SEL_W=4.
  - Function all_ones(mask).
- One natural sub-module: demux_out_reg, a 1-entry valid/ready register holding data+mask with a "load" input.
- Staging, mask logic and the FSM stay in bit_demux16.

Test Plan:
- Sequential fill: sel 0..15 with bits of 16'hA5C3, out_ready=1 → one cycle after the sel=15 beat: out_valid=1, out_data=16'hA5C3, out_mask=16'hFFFF, dup_err never set.
- Out-of-order fill: sel 15 down to 0 with bits of 16'h1234 → identical word 16'h1234; then out_ready pulse → out_valid=0 next cycle.
- Partial flush: beats sel=3 bit=1, sel=7 bit=1, then flush with no beat → out_data=16'h0088, out_mask=16'h0088. Flush with mask=0 → no out_valid.
- Duplicate write: sel=2 bit=1, then sel=2 bit=0 → dup_err high exactly 1 cycle after the second beat; after flush, out_data=0, out_mask=16'h0004.
- Backpressure: out_ready=0, fill word A=16'hFFFF then word B=16'h00FF.
  - B's closing beat → HOLD, in_ready=0, out_data stays 16'hFFFF.
  - Raise out_ready for 1 cycle → next cycle out_data=16'h00FF, out_valid still 1, in_ready=1.
- Async reset: assert rst_n=0 mid-word (mask=16'h00F0) and again in HOLD → all outputs 0 without a clock edge. After release, a fresh full fill yields only the new word.
